strobe_period_meter: RTL and testbench
======================================

# strobe_period_meter

Measures the spacing of a single-cycle strobe train, such as a sample-rate tick from the clock divider, and recovers the limit value that produced it. A strobe every L+1 cycles reports `period` = L. The block also declares lock after a programmable run of identical measurements. It sits on the consuming side of a tick line, for audio-path rate checking and for auto-configuring downstream blocks.

## Interface
- `BITLEN`, 8: width of the interval counter and of `period`. Measurable L is 0 to 2^BITLEN-1.
- `LOCK_CNT`, 4: consecutive identical measurements required to assert `locked`. Must be ≥1, and `match_cnt` is sized to hold it.
- `clk`  in  1  system clock; all logic on its rising edge.
- `n_rst`  in  1  synchronous, active-high reset. Clears all state on the next rising edge of `clk`.
- `strobe_in`  in  1  tick input, sampled every cycle. Each cycle it is high counts as one event, so a constant high is a tick every cycle (L=0).
- `period`  out  BITLEN  most recent measured interval, held between measurements.
- `valid`  out  1  one-cycle pulse when `period` is updated.
- `locked`  out  1  level; asserted while the last LOCK_CNT measurements were identical.
- `err`  out  1  one-cycle pulse when a measurement differs from the candidate while `locked` is asserted.
- `timeout`  out  1  one-cycle pulse when no event occurs for 2^BITLEN cycles after the counter saturates.

## Operation
- Internal registers:
  - `cnt` (BITLEN): cycles since the last event.
  - `cand` (BITLEN): candidate period.
  - `match_cnt`: run length of identical measurements.
  - `state`.
- `cnt` update:
  - Event cycle: `cnt` ← 0.
  - Otherwise: `cnt` ← `cnt`+1, saturating at all-ones.
- Measurement value = `cnt` sampled in the event cycle. With events at cycles 0 and L+1, the measurement is L.
- States:
  - **IDLE**: no reference event yet. An event moves to ARMED and clears `cnt`; no measurement is taken.
  - **ARMED**: first interval in progress. The next event takes measurement m: `cand`←m, `match_cnt`←1, `period`←m, `valid` pulses. Goes to LOCKED if LOCK_CNT=1, otherwise TRACK.
  - **TRACK**: every event takes a measurement and updates `period` / `valid`.
    - m==`cand`: `match_cnt`+1. Reaching LOCK_CNT goes to LOCKED.
    - m≠`cand`: `cand`←m, `match_cnt`←1; stay in TRACK. No `err`.
  - **LOCKED**: `locked`=1.
    - m==`cand`: `period`/`valid` update; stay in LOCKED.
    - m≠`cand`: `err` pulses, `locked` drops, `cand`←m, `match_cnt`←1, go to TRACK. If LOCK_CNT=1, stay in LOCKED instead, still pulsing `err`.
- Timeout:
  - Condition: `cnt`==all-ones and no event in that cycle, in ARMED, TRACK or LOCKED.
  - Action: `timeout` pulses, `locked`←0, `match_cnt`←0, go to IDLE. `period` keeps its last value.
  - Not raised in IDLE.
- Counter ceiling:
  - An event in the same cycle that `cnt`==all-ones is a valid measurement of 2^BITLEN-1, with no timeout.
  - Measurable range is therefore 0 to 2^BITLEN-1. Longer gaps always time out.
- Reset (any state, including mid-interval):
  - Outputs: `period`=0, `valid`=0, `locked`=0, `err`=0, `timeout`=0.
  - Internal: `cnt`=0, `cand`=0, `match_cnt`=0, state IDLE.
  - `strobe_in` is ignored during reset cycles.

## Timing
- All outputs are registered. For an event sampled in cycle E:
  - `period`/`valid` are visible in E+1.
  - `locked` rising, `locked` falling, and `err` are also visible in E+1.
- Timeout detected in cycle T appears as `timeout` high in T+1, with `locked` low in T+1.
- `valid`, `err` and `timeout` are exactly one cycle wide. `valid` and `err` may be high together; `timeout` never coincides with `valid`.
- Lock latency from the first event: (LOCK_CNT+1) events, plus one cycle.
- No handshake; the consumer must sample `period` while `valid` is high, or any time later before the next `valid`.

## Test plan
- **Steady train**: BITLEN=8, LOCK_CNT=4, strobe every 6 cycles starting at cycle 10 → `valid` pulses with `period`=5 at cycles 17, 23, 29, 35; `locked` rises at cycle 35; no `err`.
- **Constant high** from cycle 0 → `period`=0 `valid` from cycle 2 onward every cycle; `locked`=1 at cycle 5.
- **Rate change while locked**: switch from period 5 to period 9 → one `err` with `period`=9; `locked` low until three more period-9 measurements, then high again.
- **Timeout**: BITLEN=4, a single pair of strobes 4 cycles apart, then silence → `period`=3, then `timeout` pulse 16 cycles after the last event, `locked`=0, state IDLE. The next lone strobe gives no `valid`.
- **Ceiling boundary**: BITLEN=4, strobes exactly 16 cycles apart → `period`=15, `valid` asserted, no `timeout`. At 17 cycles apart → `timeout`, no `valid`.
- **Reset mid-operation**: while locked on period 5, assert `n_rst` for 1 cycle → all outputs 0 the next cycle. The following strobe produces no `valid`; relock needs 5 strobes.

Source files
------------

// File: rtl/strobe_period_meter_if.sv
// Tick input and measurement outputs of the strobe period meter.
// The meter side uses the slave modport; the tick source/consumer uses master.
interface strobe_period_meter_if #(
    parameter int BITLEN = 8
);
    logic              strobe_in;
    logic [BITLEN-1:0] period;
    logic              valid;
    logic              locked;
    logic              err;
    logic              timeout;

    modport master (
        output strobe_in,
        input  period,
        input  valid,
        input  locked,
        input  err,
        input  timeout
    );

    modport slave (
        input  strobe_in,
        output period,
        output valid,
        output locked,
        output err,
        output timeout
    );
endinterface

// File: rtl/strobe_period_meter.sv
// Measures the spacing of a single-cycle strobe train and recovers the
// divider limit L (strobe every L+1 cycles); declares lock on a stable run.
module strobe_period_meter #(
    parameter int BITLEN   = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    strobe_period_meter_if.slave  bus
);
    localparam int MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_TRACK  = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    localparam logic [BITLEN-1:0] CNT_MAX = '1;
    localparam logic [MW-1:0]     LOCK_N  = MW'(LOCK_CNT);
    localparam logic [MW-1:0]     ONE     = MW'(1);
    localparam bit                SINGLE  = (LOCK_CNT == 1);

    logic [1:0]        state;
    logic [BITLEN-1:0] cnt;
    logic [BITLEN-1:0] cand;
    logic [MW-1:0]     match_cnt;
    logic [BITLEN-1:0] period_q;
    logic              valid_q;
    logic              locked_q;
    logic              err_q;
    logic              timeout_q;

    logic              ev;
    logic              hit;
    logic              tmo;
    logic [MW-1:0]     match_inc;

    assign ev        = bus.strobe_in;
    assign hit       = (cnt == cand);
    assign match_inc = match_cnt + ONE;
    // An event on the saturated count is still a valid measurement.
    assign tmo       = !ev && (cnt == CNT_MAX) && (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cand      <= '0;
            match_cnt <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;

            if (ev)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            unique case (1'b1)
                tmo: begin
                    timeout_q <= 1'b1;
                    locked_q  <= 1'b0;
                    match_cnt <= '0;
                    state     <= S_IDLE;
                end
                ev: begin
                    unique case (state)
                        S_IDLE: begin
                            state <= S_ARMED;
                        end
                        S_ARMED: begin
                            period_q  <= cnt;
                            valid_q   <= 1'b1;
                            cand      <= cnt;
                            match_cnt <= ONE;
                            state     <= SINGLE ? S_LOCKED : S_TRACK;
                            locked_q  <= SINGLE;
                        end
                        S_TRACK: begin
                            period_q <= cnt;
                            valid_q  <= 1'b1;
                            if (hit) begin
                                match_cnt <= match_inc;
                                if (match_inc == LOCK_N) begin
                                    state    <= S_LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                cand      <= cnt;
                                match_cnt <= ONE;
                            end
                        end
                        S_LOCKED: begin
                            period_q <= cnt;
                            valid_q  <= 1'b1;
                            if (!hit) begin
                                err_q     <= 1'b1;
                                cand      <= cnt;
                                match_cnt <= ONE;
                                // A one-deep lock relocks on the new value at once.
                                if (!SINGLE) begin
                                    locked_q <= 1'b0;
                                    state    <= S_TRACK;
                                end
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.period  = period_q;
    assign bus.valid   = valid_q;
    assign bus.locked  = locked_q;
    assign bus.err     = err_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_strobe_period_meter.sv
// Directed bench for strobe_period_meter: an 8-bit and a 4-bit instance,
// both with LOCK_CNT=4, driven from one linear stimulus sequence.
module tb_strobe_period_meter;
    logic clk;
    logic n_rst;
    int   n_vec;
    int   n_err;
    logic to4;
    logic to8;

    strobe_period_meter_if #(.BITLEN(8)) if8 ();
    strobe_period_meter_if #(.BITLEN(4)) if4 ();

    strobe_period_meter #(.BITLEN(8), .LOCK_CNT(4)) dut8 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if8)
    );

    strobe_period_meter #(.BITLEN(4), .LOCK_CNT(4)) dut4 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic s8, input logic s4);
        if8.strobe_in = s8;
        if4.strobe_in = s4;
        @(posedge clk);
        #1;
        if (if4.timeout) to4 = 1'b1;
        if (if8.timeout) to8 = 1'b1;
    endtask

    // n ticks with the selected strobe on the last one; the first tick
    // checks that the previous valid/err pulses were one cycle wide.
    task automatic gap(input int which, input int n);
        tick(1'b0, 1'b0);
        if (which == 8) begin
            chk("pulse8_valid", 32'(if8.valid), 0);
            chk("pulse8_err", 32'(if8.err), 0);
        end else begin
            chk("pulse4_valid", 32'(if4.valid), 0);
            chk("pulse4_err", 32'(if4.err), 0);
        end
        for (int i = 0; i < n - 2; i++) tick(1'b0, 1'b0);
        tick(which == 8, which == 4);
    endtask

    task automatic exp8(input string tag, input logic v, input int p,
                        input logic l, input logic e);
        chk({tag, "_valid"}, 32'(if8.valid), 32'(v));
        chk({tag, "_period"}, 32'(if8.period), p);
        chk({tag, "_locked"}, 32'(if8.locked), 32'(l));
        chk({tag, "_err"}, 32'(if8.err), 32'(e));
    endtask

    task automatic exp4(input string tag, input logic v, input int p,
                        input logic l, input logic t);
        chk({tag, "_valid"}, 32'(if4.valid), 32'(v));
        chk({tag, "_period"}, 32'(if4.period), p);
        chk({tag, "_locked"}, 32'(if4.locked), 32'(l));
        chk({tag, "_timeout"}, 32'(if4.timeout), 32'(t));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        to4   = 1'b0;
        to8   = 1'b0;
        n_rst = 1'b1;
        if8.strobe_in = 1'b0;
        if4.strobe_in = 1'b0;

        tick(1'b1, 1'b1);
        n_rst = 1'b0;
        exp8("rst8", 0, 0, 0, 0);
        chk("rst8_timeout", 32'(if8.timeout), 0);
        exp4("rst4", 0, 0, 0, 0);
        chk("rst4_err", 32'(if4.err), 0);

        // steady train, strobe every 6 cycles
        tick(1'b1, 1'b0);
        exp8("ref8", 0, 0, 0, 0);
        gap(8, 6);
        exp8("st1", 1, 5, 0, 0);
        gap(8, 6);
        exp8("st2", 1, 5, 0, 0);
        gap(8, 6);
        exp8("st3", 1, 5, 0, 0);
        gap(8, 6);
        exp8("st4", 1, 5, 1, 0);

        // rate change while locked: 5 -> 9
        gap(8, 10);
        exp8("rc1", 1, 9, 0, 1);
        gap(8, 10);
        exp8("rc2", 1, 9, 0, 0);
        gap(8, 10);
        exp8("rc3", 1, 9, 0, 0);
        gap(8, 10);
        exp8("rc4", 1, 9, 1, 0);

        // reset mid-operation, strobe held high during reset
        n_rst = 1'b1;
        tick(1'b1, 1'b0);
        n_rst = 1'b0;
        exp8("mrst", 0, 0, 0, 0);
        chk("mrst_timeout", 32'(if8.timeout), 0);
        gap(8, 6);
        exp8("rl0", 0, 0, 0, 0);
        gap(8, 6);
        exp8("rl1", 1, 5, 0, 0);
        gap(8, 6);
        gap(8, 6);
        exp8("rl3", 1, 5, 0, 0);
        gap(8, 6);
        exp8("rl4", 1, 5, 1, 0);

        // constant high
        n_rst = 1'b1;
        tick(1'b0, 1'b0);
        n_rst = 1'b0;
        tick(1'b1, 1'b0);
        exp8("ch0", 0, 0, 0, 0);
        tick(1'b1, 1'b0);
        exp8("ch1", 1, 0, 0, 0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        exp8("ch3", 1, 0, 0, 0);
        tick(1'b1, 1'b0);
        exp8("ch4", 1, 0, 1, 0);
        tick(1'b0, 1'b0);
        exp8("ch_gap", 0, 0, 1, 0);
        tick(1'b1, 1'b0);
        exp8("ch_err", 1, 1, 0, 1);
        chk("no_timeout8", 32'(to8), 0);

        // 4-bit instance: timeout after a single measurement
        n_rst = 1'b1;
        tick(1'b0, 1'b0);
        n_rst = 1'b0;
        exp4("r4", 0, 0, 0, 0);
        to4 = 1'b0;
        tick(1'b0, 1'b1);
        exp4("t_ref", 0, 0, 0, 0);
        gap(4, 4);
        exp4("t_meas", 1, 3, 0, 0);
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b0);
        chk("t_early", 32'(to4), 0);
        tick(1'b0, 1'b0);
        exp4("t_fire", 0, 3, 0, 1);
        tick(1'b0, 1'b0);
        exp4("t_width", 0, 3, 0, 0);
        tick(1'b0, 1'b1);
        exp4("t_lone", 0, 3, 0, 0);

        // ceiling: 16 apart measures 15, 17 apart times out
        to4 = 1'b0;
        gap(4, 16);
        exp4("c16", 1, 15, 0, 0);
        chk("c16_no_to", 32'(to4), 0);
        to4 = 1'b0;
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("c17_to", 32'(to4), 1);
        exp4("c17", 0, 15, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
